// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: opcode constants, FSM state encoding and opcode
// classification helpers shared by the memory-access stage.
package mem_stage_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_load_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return is_load_op(op) | is_store_op(op);
  endfunction

  // Halfword needs addr[0]==0, word needs addr[1:0]==0.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] b);
    case (op)
      OP_LH, OP_LHU, OP_SH: return b[0];
      OP_LW, OP_SW:         return b != 2'b00;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational byte-lane formatting for the memory stage.
//   Store side: st_op_i/st_b_i/st_data_i -> be_o (byte enables, lane0 =
//   bits[7:0]) and wdata_o (store data replicated into lanes). Loads get
//   be_o = 4'b1111.
//   Load side: ld_op_i/ld_b_i/rdata_i -> ldata_o (selected byte/half/word,
//   sign- or zero-extended; 0 for non-loads).
module mem_lane_fmt
  import mem_stage_pkg::*;
(
  input  logic [5:0]  st_op_i,
  input  logic [1:0]  st_b_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [5:0]  ld_op_i,
  input  logic [1:0]  ld_b_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ldata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be_o    = '1;
    wdata_o = st_data_i;
    case (st_op_i)
      OP_SB: begin
        be_o    = 4'b0001 << st_b_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      OP_SH: begin
        be_o    = st_b_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{st_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v  = rdata_i[{ld_b_i, 3'b000} +: 8];
    half_v  = rdata_i[{ld_b_i[1], 4'b0000} +: 16];
    ldata_o = '0;
    case (ld_op_i)
      OP_LB:  ldata_o = {{24{byte_v[7]}}, byte_v};
      OP_LBU: ldata_o = {24'h0, byte_v};
      OP_LH:  ldata_o = {{16{half_v[15]}}, half_v};
      OP_LHU: ldata_o = {16'h0, half_v};
      OP_LW:  ldata_o = rdata_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and write-back.
//   Accepts an instruction (in_valid/in_ready), issues load/store over a
//   req/ack data-memory port (dm_*), aborts with err after TIMEOUT
//   unacknowledged cycles, and hands Ins_o/Result_o/MemData/err to
//   write-back with a one-cycle out_valid strobe.
//   Ports: CLK, RST (sync, active-high); in_valid/in_ready, Ins, Result,
//   Rdata2 from execute; dm_req/dm_we/dm_addr/dm_be/dm_wdata/dm_rdata/
//   dm_ack to memory; out_valid/Ins_o/Result_o/MemData/err to write-back.
//   Optional macro MEM_MISALIGN_EXC_EN: misaligned halfword/word accesses
//   raise err without a memory request.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] Ins,
  input  logic [31:0] Result,
  input  logic [31:0] Rdata2,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        out_valid,
  output logic [31:0] Ins_o,
  output logic [31:0] Result_o,
  output logic [31:0] MemData,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       ins_q, ins_d;
  logic [31:0]       res_q, res_d;
  logic [31:0]       md_q, md_d;
  logic              err_q, err_d;
  logic              ov_q, ov_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [5:0]        op_in, op_q;
  logic [3:0]        fmt_be;
  logic [31:0]       fmt_wdata;
  logic [31:0]       fmt_ldata;

  assign op_in = Ins[31:26];
  assign op_q  = ins_q[31:26];

  mem_lane_fmt u_fmt (
    .st_op_i   (op_in),
    .st_b_i    (Result[1:0]),
    .st_data_i (Rdata2),
    .be_o      (fmt_be),
    .wdata_o   (fmt_wdata),
    .ld_op_i   (op_q),
    .ld_b_i    (res_q[1:0]),
    .rdata_i   (dm_rdata),
    .ldata_o   (fmt_ldata)
  );

`ifdef MEM_MISALIGN_EXC_EN
  logic mis_q, mis_d;
  // A misaligned access spends its one WAIT cycle with dm_req held low and
  // then reports err, keeping out_valid two cycles after acceptance.
  assign dm_req = (state_q == WAIT) && !mis_q;
`else
  assign dm_req = (state_q == WAIT);
`endif

  assign in_ready  = (state_q == IDLE);
  assign dm_we     = we_q;
  assign dm_addr   = addr_q;
  assign dm_be     = be_q;
  assign dm_wdata  = wdata_q;
  assign out_valid = ov_q;
  assign Ins_o     = ins_q;
  assign Result_o  = res_q;
  assign MemData   = md_q;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ins_d   = ins_q;
    res_d   = res_q;
    md_d    = md_q;
    err_d   = err_q;
    ov_d    = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
`ifdef MEM_MISALIGN_EXC_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          ins_d = Ins;
          res_d = Result;
          md_d  = '0;
          err_d = 1'b0;
          if (is_mem_op(op_in)) begin
            we_d    = is_store_op(op_in);
            addr_d  = {Result[31:2], 2'b00};
            be_d    = fmt_be;
            wdata_d = fmt_wdata;
            cnt_d   = '0;
            state_d = WAIT;
`ifdef MEM_MISALIGN_EXC_EN
            mis_d   = is_misaligned(op_in, Result[1:0]);
`endif
          end else begin
            ov_d = 1'b1;
          end
        end
      end
      WAIT: begin
`ifdef MEM_MISALIGN_EXC_EN
        if (mis_q) begin
          err_d   = 1'b1;
          md_d    = '0;
          ov_d    = 1'b1;
          state_d = DONE;
        end else
`endif
        // dm_ack takes priority over a simultaneous timeout.
        if (dm_ack) begin
          md_d    = is_load_op(op_q) ? fmt_ldata : '0;
          err_d   = 1'b0;
          ov_d    = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          md_d    = '0;
          err_d   = 1'b1;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ins_q   <= '0;
      res_q   <= '0;
      md_q    <= '0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
`ifdef MEM_MISALIGN_EXC_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ins_q   <= ins_d;
      res_q   <= res_d;
      md_q    <= md_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
`ifdef MEM_MISALIGN_EXC_EN
      mis_q   <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a write-back scoreboard.
module tb_mem_stage;

  localparam int unsigned TO = 12;

  logic        CLK = 1'b0;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Ins, Result, Rdata2;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata, dm_rdata;
  logic        dm_ack;
  logic        out_valid;
  logic [31:0] Ins_o, Result_o, MemData;
  logic        err;

  mem_stage #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .out_valid(out_valid), .Ins_o(Ins_o), .Result_o(Result_o),
    .MemData(MemData), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] res;
    logic [31:0] md;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Write-back monitor: every out_valid pulse must match the oldest expectation.
  always @(negedge CLK) begin
    if (!RST && out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_Ins_o", Ins_o, e.ins);
        check("wb_Result_o", Result_o, e.res);
        check("wb_MemData", MemData, e.md);
        check("wb_err", 32'(err), 32'(e.err));
      end
    end
  end

  // One memory transaction; ack_at = WAIT cycle carrying dm_ack (0 = never).
  task automatic mem_op(input string tag, input logic [5:0] op, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] rdata,
                        input int unsigned ack_at, input logic [31:0] exp_md,
                        input logic exp_err, input logic exp_we, input logic [3:0] exp_be,
                        input logic chk_wd, input logic [31:0] exp_wd);
    int unsigned n;
    logic [31:0] ins;
    ins = {op, 5'd3, 5'd4, 16'h0040};
    n = (ack_at != 0) ? ack_at : TO;
    in_valid = 1'b1; Ins = ins; Result = addr; Rdata2 = rt;
    check({tag, "_in_ready_accept"}, 32'(in_ready), 32'd1);
    sb.push_back('{ins: ins, res: addr, md: exp_md, err: exp_err});
    tick();
    in_valid = 1'b0;
    for (int unsigned k = 1; k <= n; k++) begin
      check($sformatf("%s_dm_req_c%0d", tag, k), 32'(dm_req), 32'd1);
      check($sformatf("%s_in_ready_c%0d", tag, k), 32'(in_ready), 32'd0);
      check($sformatf("%s_dm_addr_c%0d", tag, k), dm_addr, {addr[31:2], 2'b00});
      if (k == 1) begin
        check({tag, "_dm_we"}, 32'(dm_we), 32'(exp_we));
        check({tag, "_dm_be"}, 32'(dm_be), 32'(exp_be));
        if (chk_wd) check({tag, "_dm_wdata"}, dm_wdata, exp_wd);
      end
      if (k == ack_at) begin
        dm_ack = 1'b1; dm_rdata = rdata;
      end
      tick();
      dm_ack = 1'b0; dm_rdata = 32'hx;
    end
    check({tag, "_done_dm_req"}, 32'(dm_req), 32'd0);
    check({tag, "_done_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_done_out_valid"}, 32'(out_valid), 32'd1);
    tick();
    check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; Ins = '0; Result = '0; Rdata2 = '0;
    dm_rdata = '0; dm_ack = 1'b0;
    tick(); tick();
    RST = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_dm_req", 32'(dm_req), 32'd0);
    check("rst_dm_we", 32'(dm_we), 32'd0);
    check("rst_dm_addr", dm_addr, 32'd0);
    check("rst_dm_be", 32'(dm_be), 32'd0);
    check("rst_dm_wdata", dm_wdata, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_Ins_o", Ins_o, 32'd0);
    check("rst_Result_o", Result_o, 32'd0);
    check("rst_MemData", MemData, 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Non-memory stream: ADDU back to back.
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; Ins = 32'h0085_1821 | (32'(i) << 11); Result = 32'(i);
      check($sformatf("alu_in_ready_%0d", i), 32'(in_ready), 32'd1);
      sb.push_back('{ins: Ins, res: Result, md: 32'd0, err: 1'b0});
      tick();
      check($sformatf("alu_out_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    check("alu_out_valid_end", 32'(out_valid), 32'd0);

    // Loads.
    mem_op("lb",  6'h20, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 2, 32'hFFFF_FF80, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0);
    mem_op("lbu", 6'h24, 32'h0000_1003, 32'h0, 32'h80FF_FF12, 2, 32'h0000_0080, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0);
    mem_op("lh",  6'h21, 32'h0000_1002, 32'h0, 32'h80FF_FF12, 1, 32'hFFFF_80FF, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0);
    mem_op("lhu", 6'h25, 32'h0000_1000, 32'h0, 32'h80FF_FF12, 1, 32'h0000_FF12, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0);
    mem_op("lbu0",6'h24, 32'h0000_1001, 32'h0, 32'h80FF_FF12, 3, 32'h0000_00FF, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0);
    mem_op("lw",  6'h23, 32'h0000_1004, 32'h0, 32'h80FF_FF12, 1, 32'h80FF_FF12, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0);

    // Stores.
    mem_op("sh",  6'h29, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_5555, 1, 32'h0, 1'b0, 1'b1, 4'b1100, 1'b1, 32'hABCD_ABCD);
    mem_op("sh0", 6'h29, 32'h0000_2000, 32'h1234_ABCD, 32'h5555_5555, 2, 32'h0, 1'b0, 1'b1, 4'b0011, 1'b1, 32'hABCD_ABCD);
    mem_op("sb",  6'h28, 32'h0000_0011, 32'h0000_00A5, 32'h5555_5555, 1, 32'h0, 1'b0, 1'b1, 4'b0010, 1'b1, 32'hA5A5_A5A5);
    mem_op("sw",  6'h2B, 32'h0000_0020, 32'hCAFE_F00D, 32'h5555_5555, 1, 32'h0, 1'b0, 1'b1, 4'b1111, 1'b1, 32'hCAFE_F00D);

    // Timeout, then ack coinciding with the last allowed cycle.
    mem_op("lw_to",   6'h23, 32'h0000_3000, 32'h0, 32'h0, 0,  32'h0,         1'b1, 1'b0, 4'b1111, 1'b0, 32'h0);
    mem_op("lw_tack", 6'h23, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, TO, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h0);

    // Reset in the middle of WAIT; a late ack must be ignored.
    in_valid = 1'b1; Ins = {6'h23, 26'h0}; Result = 32'h0000_4000;
    tick();
    in_valid = 1'b0;
    check("rstw_dm_req_before", 32'(dm_req), 32'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("rstw_dm_req", 32'(dm_req), 32'd0);
    check("rstw_in_ready", 32'(in_ready), 32'd1);
    check("rstw_out_valid", 32'(out_valid), 32'd0);
    dm_ack = 1'b1; dm_rdata = 32'h1111_2222;
    tick();
    dm_ack = 1'b0;
    check("late_ack_out_valid", 32'(out_valid), 32'd0);
    check("late_ack_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("late_ack_out_valid2", 32'(out_valid), 32'd0);

    tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
